// File: rtl/multi_seq.sv
// Sequential shift-add multiplier: one partial product per cycle, WIDTH+1 cycle latency.
// Signed (two's complement) operation is built only when MULTI_SEQ_SIGNED_EN is defined.
module multi_seq #(
    parameter int WIDTH = 32
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 start,
    input  logic                 tc,
    input  logic [WIDTH-1:0]     mlier,
    input  logic [WIDTH-1:0]     mcand,
    output logic                 busy,
    output logic                 valid,
    output logic [2*WIDTH-1:0]   prodt
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        SIGN
    } state_t;

    state_t state;
    state_t state_nx;

    logic [2*WIDTH-1:0] acc;
    logic [2*WIDTH-1:0] mc_sh;
    logic [WIDTH-1:0]   ml_sh;
    logic [CW-1:0]      cnt;

    logic [WIDTH-1:0]   ml_mag;
    logic [WIDTH-1:0]   mc_mag;
    logic [2*WIDTH-1:0] result;

`ifdef MULTI_SEQ_SIGNED_EN
    logic neg;
    logic neg_nx;

    // The most negative operand negates to itself, which is its correct unsigned magnitude.
    always_comb begin
        ml_mag = (tc && mlier[WIDTH-1]) ? -mlier : mlier;
        mc_mag = (tc && mcand[WIDTH-1]) ? -mcand : mcand;
        neg_nx = tc & (mlier[WIDTH-1] ^ mcand[WIDTH-1]);
        result = (neg && (acc != '0)) ? -acc : acc;
    end
`else
    logic unused_tc;

    assign unused_tc = tc;
    assign ml_mag    = mlier;
    assign mc_mag    = mcand;
    assign result    = acc;
`endif

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE: begin
                if (start) begin
                    state_nx = RUN;
                end
            end
            RUN: begin
                if (cnt == CW'(1)) begin
                    state_nx = SIGN;
                end
            end
            SIGN: begin
                state_nx = IDLE;
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    always_comb begin
        busy = (state != IDLE);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            acc   <= '0;
            mc_sh <= '0;
            ml_sh <= '0;
            cnt   <= '0;
            valid <= 1'b0;
            prodt <= '0;
`ifdef MULTI_SEQ_SIGNED_EN
            neg   <= 1'b0;
`endif
        end else begin
            valid <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (start) begin
                        acc   <= '0;
                        mc_sh <= {{WIDTH{1'b0}}, mc_mag};
                        ml_sh <= ml_mag;
                        cnt   <= CW'(WIDTH);
`ifdef MULTI_SEQ_SIGNED_EN
                        neg   <= neg_nx;
`endif
                    end
                end
                RUN: begin
                    if (ml_sh[0]) begin
                        acc <= acc + mc_sh;
                    end
                    mc_sh <= mc_sh << 1;
                    ml_sh <= ml_sh >> 1;
                    cnt   <= cnt - CW'(1);
                end
                SIGN: begin
                    prodt <= result;
                    valid <= 1'b1;
                end
                default: begin
                    valid <= 1'b0;
                end
            endcase
        end
    end

endmodule
